axi4_txn_throttle: RTL
======================

Name: axi4_txn_throttle

Overview:
- Sits directly downstream of noc_axi4_bridge, between the bridge's AXI4 master port and the SoC AXI interconnect.
- Caps outstanding read and write transactions.
- Provides a drain/quiesce control.
- Reports a response watchdog timeout, error-response counts and protocol violations.
- All AXI payload signals pass through combinationally. Only AR/AW valid/ready are gated.

Parameters:
- MAX_RD_OUTSTANDING, 4, max accepted ARs without final R beat (>=1)
- MAX_WR_OUTSTANDING, 4, max accepted AWs without B (>=1)
- TIMEOUT_CYCLES, 1024, cycles without any R/B handshake while outstanding before timeout (>=2)
- ERR_CNT_WIDTH, 16, width of each error counter

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- s_axi_aw*/w*/ar*  in (ready: out)  per `AXI4_*_WIDTH  slave side from bridge: AW/W/AR payload+valid in, ready out
- s_axi_r*/b*  out (ready: in)  per `AXI4_*_WIDTH  R/B payload+valid to bridge, ready from bridge
- m_axi_aw*/w*/ar*  out (ready: in)  per `AXI4_*_WIDTH  master side to interconnect
- m_axi_r*/b*  in (ready: out)  per `AXI4_*_WIDTH  responses from interconnect
- enable_i  in  1  0 = issue no new AR/AW (drain mode)
- clear_i  in  1  synchronous clear of sticky flags and error counters
- idle_o  out  1  no outstanding reads or writes
- timeout_o  out  1  sticky watchdog flag
- protocol_err_o  out  1  sticky: response received with its count at 0
- rd_err_cnt_o  out  ERR_CNT_WIDTH  R beats with rresp[1]=1, saturating
- wr_err_cnt_o  out  ERR_CNT_WIDTH  B with bresp[1]=1, saturating

Behaviour:
- Reset: rd_cnt, wr_cnt, wdog, both err counters, timeout_o and protocol_err_o all 0; idle_o=1. Reset mid-burst drops all state immediately; gating reopens in the first cycle after reset.
- Pass-through: W, R and B channels and all payload wires are direct (0 latency). Same for m_axi_rready/bready ← s_axi_*.
- Read gate:
  - rd_full = (rd_cnt == MAX_RD_OUTSTANDING).
  - m_axi_arvalid = s_axi_arvalid & enable_i & ~rd_full.
  - s_axi_arready = m_axi_arready & enable_i & ~rd_full.
  - No same-cycle bypass: a completion in the same cycle does not unblock until the next cycle.
- Write gate: same as the read gate, using wr_cnt / MAX_WR_OUTSTANDING on AW. W is never gated.
- Counter width is $clog2(MAX+1).
  - rd_cnt: +1 on AR handshake (m side); -1 on R handshake with rlast; simultaneous events leave it unchanged.
  - wr_cnt: +1 on AW handshake; -1 on B handshake.
- Underflow: a decrement event when the count is 0 (and no simultaneous increment) sets protocol_err_o. The count stays 0.
- idle_o = (rd_cnt==0)&(wr_cnt==0), registered from the counters (combinational from registers).
- Watchdog wdog:
  - Cleared when idle or on any R or B handshake.
  - Otherwise increments, saturating at TIMEOUT_CYCLES.
  - timeout_o is set in the cycle after wdog reaches TIMEOUT_CYCLES.
- Error counters:
  - Increment on each R handshake with rresp[1]=1 (every beat, SLVERR/DECERR) and each B handshake with bresp[1]=1.
  - Saturate at all-ones.
- clear_i: zeroes the error counters, timeout_o, protocol_err_o and wdog the next cycle. If clear_i and an increment or set condition coincide, clear wins. clear_i does not touch rd_cnt/wr_cnt.
- enable_i low during outstanding traffic: responses still complete; idle_o rises when drained.

Test Plan:
- MAX_RD=4, slave holds arready=1 and returns no R: issue 6 ARs -> exactly 4 m_axi_arvalid handshakes, s_axi_arready=0 from the 5th. One rlast=1 beat -> 5th AR accepted the following cycle.
- AR handshake and R rlast handshake in the same cycle with rd_cnt=2 -> rd_cnt stays 2; idle_o=0.
- TIMEOUT_CYCLES=16, one AW accepted, B withheld -> timeout_o=1 at cycle 17 after AW. B then returns -> idle_o=1, timeout_o stays 1 until clear_i pulse.
- 4-beat read burst with rresp=2'b10 on beats 1 and 3, then B with bresp=2'b11 -> rd_err_cnt_o=2, wr_err_cnt_o=1. ERR_CNT_WIDTH=2 with 5 error beats -> saturates at 3.
- Unsolicited B with wr_cnt=0 -> protocol_err_o=1, wr_cnt=0. enable_i=0 with AR pending -> m_axi_arvalid=0 indefinitely; enable_i=1 -> issued next cycle.
- Assert rst_n low mid-burst with rd_cnt=3 -> all outputs at reset values asynchronously; after release, 4 new ARs accepted back-to-back.

Source files
------------

// File: rtl/axi4_txn_throttle.sv
// AXI4 outstanding-transaction throttle: caps accepted AR/AW, supports drain mode,
// and reports watchdog timeout, error-response counts and response underflow.
module axi4_txn_throttle #(
    parameter int MAX_RD_OUTSTANDING = 4,
    parameter int MAX_WR_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int ERR_CNT_WIDTH      = 16,
    parameter int AXI_ID_WIDTH       = 4,
    parameter int AXI_ADDR_WIDTH     = 32,
    parameter int AXI_DATA_WIDTH     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // slave side (from bridge)
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awlock,
    input  logic [3:0]                  s_axi_awcache,
    input  logic [2:0]                  s_axi_awprot,
    input  logic [3:0]                  s_axi_awqos,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arlock,
    input  logic [3:0]                  s_axi_arcache,
    input  logic [2:0]                  s_axi_arprot,
    input  logic [3:0]                  s_axi_arqos,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    // master side (to interconnect)
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                  m_axi_awlen,
    output logic [2:0]                  m_axi_awsize,
    output logic [1:0]                  m_axi_awburst,
    output logic                        m_axi_awlock,
    output logic [3:0]                  m_axi_awcache,
    output logic [2:0]                  m_axi_awprot,
    output logic [3:0]                  m_axi_awqos,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wlast,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    output logic [2:0]                  m_axi_arsize,
    output logic [1:0]                  m_axi_arburst,
    output logic                        m_axi_arlock,
    output logic [3:0]                  m_axi_arcache,
    output logic [2:0]                  m_axi_arprot,
    output logic [3:0]                  m_axi_arqos,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rlast,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    // control / status
    input  logic                        enable_i,
    input  logic                        clear_i,
    output logic                        idle_o,
    output logic                        timeout_o,
    output logic                        protocol_err_o,
    output logic [ERR_CNT_WIDTH-1:0]    rd_err_cnt_o,
    output logic [ERR_CNT_WIDTH-1:0]    wr_err_cnt_o
);
    localparam int RD_CW = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam int WR_CW = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [RD_CW-1:0]         r_rd_cnt, w_rd_cnt_next;
    logic [WR_CW-1:0]         r_wr_cnt, w_wr_cnt_next;
    logic [WD_W-1:0]          r_wdog;
    logic [ERR_CNT_WIDTH-1:0] r_rd_err, r_wr_err;
    logic                     r_timeout, r_protocol_err;
    logic                     w_rd_full, w_wr_full, w_idle;
    logic                     w_ar_hs, w_aw_hs, w_r_hs, w_r_done, w_b_hs;
    logic                     w_rd_uflow, w_wr_uflow;

    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_wvalid  = s_axi_wvalid;
    assign s_axi_wready  = m_axi_wready;
    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bresp   = m_axi_bresp;
    assign s_axi_bvalid  = m_axi_bvalid;
    assign m_axi_bready  = s_axi_bready;
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;
    assign s_axi_rid     = m_axi_rid;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rvalid  = m_axi_rvalid;
    assign m_axi_rready  = s_axi_rready;

    // Gating uses registered counts only, so a completion never unblocks in its own cycle.
    assign w_rd_full     = (r_rd_cnt == RD_CW'(MAX_RD_OUTSTANDING));
    assign w_wr_full     = (r_wr_cnt == WR_CW'(MAX_WR_OUTSTANDING));
    assign m_axi_arvalid = s_axi_arvalid & enable_i & ~w_rd_full;
    assign s_axi_arready = m_axi_arready & enable_i & ~w_rd_full;
    assign m_axi_awvalid = s_axi_awvalid & enable_i & ~w_wr_full;
    assign s_axi_awready = m_axi_awready & enable_i & ~w_wr_full;

    assign w_ar_hs  = m_axi_arvalid & m_axi_arready;
    assign w_aw_hs  = m_axi_awvalid & m_axi_awready;
    assign w_r_hs   = m_axi_rvalid & s_axi_rready;
    assign w_r_done = w_r_hs & m_axi_rlast;
    assign w_b_hs   = m_axi_bvalid & s_axi_bready;
    assign w_idle   = (r_rd_cnt == '0) && (r_wr_cnt == '0);

    always_comb begin
        w_rd_cnt_next = r_rd_cnt;
        w_rd_uflow    = 1'b0;
        if (w_ar_hs && !w_r_done) begin
            w_rd_cnt_next = r_rd_cnt + RD_CW'(1);
        end else if (!w_ar_hs && w_r_done) begin
            if (r_rd_cnt == '0) w_rd_uflow = 1'b1;
            else                w_rd_cnt_next = r_rd_cnt - RD_CW'(1);
        end
    end

    always_comb begin
        w_wr_cnt_next = r_wr_cnt;
        w_wr_uflow    = 1'b0;
        if (w_aw_hs && !w_b_hs) begin
            w_wr_cnt_next = r_wr_cnt + WR_CW'(1);
        end else if (!w_aw_hs && w_b_hs) begin
            if (r_wr_cnt == '0) w_wr_uflow = 1'b1;
            else                w_wr_cnt_next = r_wr_cnt - WR_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_rd_cnt <= w_rd_cnt_next;
            r_wr_cnt <= w_wr_cnt_next;
        end
    end

    // Status state: clear_i takes priority over any same-cycle increment or set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog         <= '0;
            r_timeout      <= 1'b0;
            r_protocol_err <= 1'b0;
            r_rd_err       <= '0;
            r_wr_err       <= '0;
        end else if (clear_i) begin
            r_wdog         <= '0;
            r_timeout      <= 1'b0;
            r_protocol_err <= 1'b0;
            r_rd_err       <= '0;
            r_wr_err       <= '0;
        end else begin
            if (w_idle || w_r_hs || w_b_hs)
                r_wdog <= '0;
            else if (r_wdog != WD_W'(TIMEOUT_CYCLES))
                r_wdog <= r_wdog + WD_W'(1);
            if (r_wdog == WD_W'(TIMEOUT_CYCLES))
                r_timeout <= 1'b1;
            if (w_rd_uflow || w_wr_uflow)
                r_protocol_err <= 1'b1;
            if (w_r_hs && m_axi_rresp[1] && (r_rd_err != '1))
                r_rd_err <= r_rd_err + ERR_CNT_WIDTH'(1);
            if (w_b_hs && m_axi_bresp[1] && (r_wr_err != '1))
                r_wr_err <= r_wr_err + ERR_CNT_WIDTH'(1);
        end
    end

    assign idle_o         = w_idle;
    assign timeout_o      = r_timeout;
    assign protocol_err_o = r_protocol_err;
    assign rd_err_cnt_o   = r_rd_err;
    assign wr_err_cnt_o   = r_wr_err;
endmodule
